arb_rr_8x3: RTL

//   8-requester round-robin arbiter for a shared resource. Turns a registered
//   one-hot grant into a 3-bit grant index (8x3 encode), so the index can drive
//   a shared mux or bus select. A grant is held until the owner pulses done,

---
 rtl/arb_rr_8x3.sv | 129 ++++++++++++
 1 files changed

// File: rtl/arb_rr_8x3.sv
// 8-requester round-robin arbiter with registered one-hot grant and 3-bit index.
// Define ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles.
module arb_rr_8x3 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_r;
    logic [2:0] ptr_r;
    logic [7:0] gnt_r;
    logic [2:0] gnt_idx_r;
    logic       gnt_valid_r;
    logic       win_found_s;
    logic [2:0] win_idx_s;
    logic [2:0] cand_s;
    logic       expire_s;
    logic       release_s;

    // Out-of-range configurations leave this block populated as a marker for review.
    if (MAX_HOLD < 2 || MAX_HOLD > 256 || (2 ** CNT_W) < MAX_HOLD) begin : g_bad_params
    end

    // Winner search: walk downward so the candidate closest to ptr is written last.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        cand_s      = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            cand_s = ptr_r + 3'(k);
            if (req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_r;
    logic             timeout_r;

    assign expire_s = (state_r == ST_GRANT) && !done &&
                      (hold_cnt_r == CNT_W'(MAX_HOLD - 1));

    // Hold counter: zero outside a held grant, so every new grant starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_GRANT && !release_s) begin
            hold_cnt_r <= hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            hold_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Timeout pulse lines up with the grant change it causes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= expire_s;
        end
    end

    assign timeout = timeout_r;
`else
    assign expire_s = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign release_s = (state_r == ST_GRANT) && (done || expire_s);

    // Arbitration FSM: grant from IDLE, or hand over directly on release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 3'd0;
            gnt_r       <= 8'h00;
            gnt_idx_r   <= 3'd0;
            gnt_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_GRANT: begin
                    if (state_r == ST_GRANT && !release_s) begin
                        state_r <= ST_GRANT;
                    end else if (en && win_found_s) begin
                        state_r     <= ST_GRANT;
                        ptr_r       <= win_idx_s + 3'd1;
                        gnt_r       <= 8'd1 << win_idx_s;
                        gnt_idx_r   <= win_idx_s;
                        gnt_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                        gnt_r       <= 8'h00;
                        gnt_idx_r   <= 3'd0;
                        gnt_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    gnt_r       <= 8'h00;
                    gnt_idx_r   <= 3'd0;
                    gnt_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign gnt_idx   = gnt_idx_r;
    assign gnt_valid = gnt_valid_r;

endmodule
